// File: rtl/dsp_pkg.sv
// Shared defaults and sizing helpers for the DSP issue/return controller.
package dsp_pkg;

  localparam int A_W_DEF       = 18;
  localparam int C_W_DEF       = 48;
  localparam int DSP_LAT_DEF   = 4;
  localparam int RES_DEPTH_DEF = 8;

  // Width needed to hold every value from 0 to depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dsp_result_fifo.sv
// First-word fall-through result FIFO; depth need not be a power of two.
module dsp_result_fifo
  import dsp_pkg::*;
#(
  parameter int WIDTH = C_W_DEF,
  parameter int DEPTH = RES_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [WIDTH-1:0]          din,
  input  logic                      pop,
  output logic [WIDTH-1:0]          dout,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) return '0;
    return ptr + 1'b1;
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dsp_issue_ctrl.sv
// Issues operand sets to the DSP slice, tracks their latency with a tag pipe
// and returns results in issue order under credit-based flow control.
module dsp_issue_ctrl
  import dsp_pkg::*;
#(
  parameter int A_W       = A_W_DEF,
  parameter int C_W       = C_W_DEF,
  parameter int DSP_LAT   = DSP_LAT_DEF,
  parameter int RES_DEPTH = RES_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [A_W-1:0]                in_a,
  input  logic [A_W-1:0]                in_b,
  input  logic [C_W-1:0]                in_c,
  input  logic [A_W-1:0]                in_d,
  output logic [A_W-1:0]                dsp_a,
  output logic [A_W-1:0]                dsp_b,
  output logic [C_W-1:0]                dsp_c,
  output logic [A_W-1:0]                dsp_d,
  input  logic [C_W-1:0]                dsp_p,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [C_W-1:0]                out_p,
  output logic [cnt_w(RES_DEPTH)-1:0]   inflight,
  output logic                          busy
);

  localparam int CNT_W = cnt_w(RES_DEPTH);

  logic [A_W-1:0]     dsp_a_q, dsp_b_q, dsp_d_q;
  logic [C_W-1:0]     dsp_c_q;
  logic [DSP_LAT-1:0] tag_q, tag_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic               issue, pop;
  logic               fifo_push, fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  // Credits cover both the tag pipe and the FIFO, so a maturing op always has a slot.
  assign in_ready = (inflight_q < CNT_W'(RES_DEPTH));
  assign issue    = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign inflight = inflight_q;
  assign busy     = (inflight_q != '0);

  assign dsp_a = dsp_a_q;
  assign dsp_b = dsp_b_q;
  assign dsp_c = dsp_c_q;
  assign dsp_d = dsp_d_q;

  generate
    if (DSP_LAT == 1) begin : g_tag_single
      assign tag_d = issue;
    end else begin : g_tag_shift
      assign tag_d = {tag_q[DSP_LAT-2:0], issue};
    end
  endgenerate

  assign fifo_push = tag_q[DSP_LAT-1];

  always_comb begin
    inflight_d = inflight_q;
    case ({issue, pop})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q      <= '0;
      inflight_q <= '0;
    end else begin
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  // Operand registers hold between issues so the DSP sees stable inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsp_a_q <= '0;
      dsp_b_q <= '0;
      dsp_c_q <= '0;
      dsp_d_q <= '0;
    end else if (issue) begin
      dsp_a_q <= in_a;
      dsp_b_q <= in_b;
      dsp_c_q <= in_c;
      dsp_d_q <= in_d;
    end
  end

  dsp_result_fifo #(
    .WIDTH (C_W),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (dsp_p),
    .pop   (pop),
    .dout  (out_p),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = ~fifo_empty;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && fifo_full && !pop));
  a_count_le_credit: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_count <= inflight_q);

endmodule

// File: tb/tb_dsp_issue_ctrl.sv
// Randomized scoreboard bench for dsp_issue_ctrl driving dsp_p from a pipelined a*b+c model.
module tb_dsp_issue_ctrl;

  localparam int A_W       = 18;
  localparam int C_W       = 48;
  localparam int DSP_LAT   = 4;
  localparam int RES_DEPTH = 8;
  localparam int CNT_W     = $clog2(RES_DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [A_W-1:0]   in_a, in_b, in_d;
  logic [C_W-1:0]   in_c;
  logic [A_W-1:0]   dsp_a, dsp_b, dsp_d;
  logic [C_W-1:0]   dsp_c, dsp_p;
  logic             out_valid, out_ready;
  logic [C_W-1:0]   out_p;
  logic [CNT_W-1:0] inflight;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_issued = 0;
  int n_pops   = 0;
  logic [C_W-1:0] exp_q[$];

  dsp_issue_ctrl #(
    .A_W(A_W), .C_W(C_W), .DSP_LAT(DSP_LAT), .RES_DEPTH(RES_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c), .dsp_d(dsp_d),
    .dsp_p(dsp_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .inflight(inflight), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DSP model: p reflects operands loaded at edge N when sampled at edge N+DSP_LAT.
  logic [C_W-1:0] dsp_pipe [DSP_LAT-1];
  always @(posedge clk) begin
    dsp_pipe[0] <= C_W'(dsp_a) * C_W'(dsp_b) + dsp_c;
    for (int i = 1; i < DSP_LAT - 1; i++) dsp_pipe[i] <= dsp_pipe[i-1];
  end
  assign dsp_p = dsp_pipe[DSP_LAT-2];

  function automatic logic [C_W-1:0] ref_p(input logic [A_W-1:0] a, input logic [A_W-1:0] b,
                                           input logic [C_W-1:0] c);
    logic [63:0] full_p;
    full_p = 64'(a) * 64'(b) + 64'(c);
    return full_p[C_W-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: handshakes seen here complete on the following rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      check("inflight", 64'(inflight), 64'(exp_q.size()));
      check("in_ready", 64'(in_ready), 64'(exp_q.size() < RES_DEPTH));
      check("busy", 64'(busy), 64'(exp_q.size() != 0));
      if (!out_valid) check("out_p_idle", 64'(out_p), 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(out_valid), 64'd0);
        end else begin
          check("out_p", 64'(out_p), 64'(exp_q.pop_front()));
          n_pops++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_p(in_a, in_b, in_c));
        n_issued++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    in_a = A_W'($urandom);
    in_b = A_W'($urandom);
    in_d = A_W'($urandom);
    in_c = {$urandom, $urandom};
  endtask

  task automatic drain();
    int cnt = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && cnt < 200) begin
      step();
      cnt++;
    end
    step();
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int iss0, pops0, cnt;
    bit seen_first;

    // Reset with activity on the inputs.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (5) begin
      rand_ops();
      out_ready = 1'($urandom);
      #10;
    end
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_p", 64'(out_p), 64'd0);
    check("rst_inflight", 64'(inflight), 64'd0);
    check("rst_dsp_a", 64'(dsp_a), 64'd0);
    check("rst_dsp_d", 64'(dsp_d), 64'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);
    step();

    // Single op: result appears in the DSP_LAT+1'th cycle counting the issue cycle.
    out_ready = 1'b1;
    in_a = 3; in_b = 5; in_c = 7; in_d = 0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k < DSP_LAT; k++) begin
      step();
      check("single_early_valid", 64'(out_valid), 64'd0);
    end
    step();
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_p", 64'(out_p), 64'd22);
    step();
    check("single_inflight", 64'(inflight), 64'd0);

    // Streaming: 100 back-to-back ops, no gaps once results begin.
    pops0 = n_pops;
    seen_first = 1'b0;
    for (int cyc = 0; cyc < 130; cyc++) begin
      if (cyc < 100) begin
        rand_ops();
        in_valid = 1'b1;
        check("stream_in_ready", 64'(in_ready), 64'd1);
      end else begin
        in_valid = 1'b0;
      end
      if (seen_first && (n_pops - pops0) < 100) check("stream_gap", 64'(out_valid), 64'd1);
      if (out_valid) seen_first = 1'b1;
      step();
    end
    check("stream_count", 64'(n_pops - pops0), 64'd100);
    drain();

    // Backpressure: credits run out after RES_DEPTH accepted ops.
    iss0 = n_issued;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      rand_ops();
      in_valid = 1'b1;
      step();
    end
    check("bp_accepted", 64'(n_issued - iss0), 64'(RES_DEPTH));
    check("bp_inflight", 64'(inflight), 64'(RES_DEPTH));
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    pops0 = n_pops;
    drain();
    check("bp_pops", 64'(n_pops - pops0), 64'(RES_DEPTH));
    check("bp_in_ready_after", 64'(in_ready), 64'd1);

    // Full FIFO with simultaneous push/pop while out_ready toggles.
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      rand_ops();
      in_valid = 1'b1;
      step();
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      rand_ops();
      in_valid  = 1'b1;
      out_ready = cyc[0];
      check("toggle_inflight_max", 64'(inflight <= CNT_W'(RES_DEPTH)), 64'd1);
      step();
    end
    drain();
    check("toggle_balance", 64'(n_issued - n_pops), 64'd0);

    // Reset mid-operation: no stale results afterwards.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #12;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_inflight", 64'(inflight), 64'd0);
    #5 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("postrst_no_stale", 64'(out_valid), 64'd0);
    end
    in_a = 100; in_b = 200; in_c = 1; in_d = 0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      step();
      cnt++;
    end
    check("fresh_valid", 64'(out_valid), 64'd1);
    check("fresh_p", 64'(out_p), 64'd20001);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
